// File: rtl/tile_load_scheduler.sv
// Round-robin arbiter in front of the single DRAM tile loader: grants one (addr, length)
// request at a time, forwards returned tiles to the winner and reports done or timeout.
module tile_load_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int TILE_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*24-1:0]      req_addr,
  input  logic [NUM_REQ*20-1:0]      req_length,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       ld_valid_in,
  output logic [23:0]                ld_dram_addr,
  output logic [19:0]                ld_length,
  output logic                       ld_abort,
  input  logic [TILE_WIDTH-1:0]      ld_data_out,
  input  logic                       ld_tile_out,
  input  logic                       ld_valid_out,
  output logic [TILE_WIDTH-1:0]      tile_data,
  output logic [NUM_REQ-1:0]         tile_valid,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         error,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [15:0]                tile_count,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Handshakes: req_valid[i] is held with stable addr/length until the one-cycle
  // req_ready[i] pulse (the ISSUE cycle); the requester may drop it after that edge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      rr_winner;
  logic               rr_found;
  int                 rr_idx;
  logic [TW-1:0]      to_cnt;
  logic               strobe;
  logic               timeout_hit;
  logic [NUM_REQ-1:0] grant_mask;

  // Search starts just past the previous winner so every pending requester is served in turn.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = int'(last_grant) + 1 + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!rr_found && req_valid[GW'(rr_idx)]) begin
        rr_found  = 1'b1;
        rr_winner = GW'(rr_idx);
      end
    end
  end

  always_comb begin
    grant_mask           = '0;
    grant_mask[grant_id] = 1'b1;
  end

  assign strobe      = ld_tile_out | ld_valid_out;
  assign timeout_hit = (to_cnt == TO_LAST) && !strobe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ld_valid_in = 1'b0;
    req_ready   = '0;
    case (state)
      IDLE:   if (rr_found) state_nx = ISSUE;
      ISSUE: begin
        ld_valid_in = 1'b1;
        req_ready   = grant_mask;
        state_nx    = WAIT;
      end
      WAIT:   if (ld_valid_out || timeout_hit) state_nx = FINISH;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= GW'(NUM_REQ - 1);
      grant_id     <= '0;
      ld_dram_addr <= '0;
      ld_length    <= '0;
      ld_abort     <= 1'b0;
      tile_data    <= '0;
      tile_valid   <= '0;
      done         <= '0;
      error        <= '0;
      tile_count   <= '0;
      to_cnt       <= '0;
    end else begin
      tile_valid <= '0;
      done       <= '0;
      error      <= '0;
      ld_abort   <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_found) begin
            ld_dram_addr <= req_addr[24*rr_winner +: 24];
            ld_length    <= req_length[20*rr_winner +: 20];
            grant_id     <= rr_winner;
            tile_count   <= '0;
          end
        end
        ISSUE: begin
          last_grant <= grant_id;
          to_cnt     <= '0;
        end
        WAIT: begin
          if (ld_tile_out) begin
            tile_data  <= ld_data_out;
            tile_valid <= grant_mask;
            if (tile_count != 16'hFFFF) tile_count <= tile_count + 16'd1;
          end
          if (strobe) to_cnt <= '0;
          else        to_cnt <= to_cnt + TW'(1);
          // Completion wins over a timeout landing on the same cycle.
          if (ld_valid_out) begin
            done <= grant_mask;
          end else if (timeout_hit) begin
            error    <= grant_mask;
            ld_abort <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
